// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : opcode constants and fetch FSM encoding shared by fetch and decode
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int OP_W    = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_RSP  = 2'd2
  } fetch_state_e;

  function automatic logic op_supported(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTIU, OP_BEQ, OP_LUI, OP_ORI, OP_BNE: op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : synchronous {pc, instr} buffer with flush, registered storage
// Rev 1.0
// ============================================================================
module fetch_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  output logic [INSTR_W-1:0] head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [INSTR_W-1:0] pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign do_pop     = pop && !empty;
  // A full buffer still takes a word when the head leaves in the same cycle
  assign do_push    = push && (!full || do_pop);
  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : single-outstanding MIPS fetch with redirect and buffer
// Rev 1.0
// ============================================================================
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [31:0]        imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        instr_pc_o,
  output logic [OP_W-1:0]    instr_op_o,
  output logic               instr_illegal_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  logic [31:0]   pc;
  logic          drop;
  logic [31:0]   redir_pc;
  logic          has_space;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign redir_pc  = {redirect_pc_i[31:2], 2'b00};
  assign has_space = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_pop  = instr_valid_o && instr_ready_i;
  // imem_addr_o still holds the address of the request being answered
  assign fifo_push = (state == FETCH_RSP) && imem_rvalid_i && !drop && !redirect_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= FETCH_IDLE;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      if (redirect_i) begin
        pc <= redir_pc;
      end
      case (state)
        FETCH_IDLE: begin
          if (has_space || redirect_i) begin
            state       <= FETCH_REQ;
            imem_req_o  <= 1'b1;
            imem_addr_o <= redirect_i ? redir_pc : pc;
          end
        end
        FETCH_REQ: begin
          // The issued request cannot be withdrawn; mark its response as stale
          if (redirect_i) begin
            drop <= 1'b1;
          end
          if (imem_gnt_i) begin
            state      <= FETCH_RSP;
            imem_req_o <= 1'b0;
            if (!redirect_i && !drop) begin
              pc <= pc + 32'd4;
            end
          end
        end
        FETCH_RSP: begin
          if (imem_rvalid_i) begin
            state <= FETCH_IDLE;
            drop  <= 1'b0;
          end else if (redirect_i) begin
            drop <= 1'b1;
          end
        end
        default: begin
          state      <= FETCH_IDLE;
          imem_req_o <= 1'b0;
          drop       <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .flush      (redirect_i),
    .push       (fifo_push),
    .push_pc    (imem_addr_o),
    .push_instr (imem_rdata_i),
    .pop        (fifo_pop),
    .head_pc    (instr_pc_o),
    .head_instr (instr_o),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign instr_valid_o   = !fifo_empty;
  assign instr_op_o      = instr_o[31:26];
  assign instr_illegal_o = instr_valid_o && !op_supported(instr_op_o);

  push_never_overflows_a : assert property (@(posedge clk_i) disable iff (!rst_i)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// Bench for instr_fetch_unit: random memory/decode behaviour, expected
// instruction stream kept as a queue of {pc, word} and checked on every pop.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [5:0]  instr_op_o;
  logic        instr_illegal_o;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_pc_i   (redirect_pc_i),
    .instr_valid_o   (instr_valid_o),
    .instr_ready_i   (instr_ready_i),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_op_o      (instr_op_o),
    .instr_illegal_o (instr_illegal_o)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int pops         = 0;

  bit          mem_fixed_en = 1'b1;
  logic [31:0] mem_fixed    = 32'h2008_0005;
  int          gnt_pct      = 100;
  int          lat_min      = 1;
  int          lat_max      = 1;
  bit          gnt_block    = 1'b0;

  logic [31:0] req_log [$];
  logic [63:0] exp_q   [$];
  logic [63:0] next_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out or unexpected event", name);
  endtask

  // Instruction memory contents: a fixed word, or a hash of the address
  function automatic logic [31:0] memword(input logic [31:0] a);
    logic [31:0] h;
    logic [5:0]  op;
    if (mem_fixed_en) return mem_fixed;
    h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
    case (h[31:28] % 10)
      0: op = 6'b000000;
      1: op = 6'b001000;
      2: op = 6'b001011;
      3: op = 6'b000100;
      4: op = 6'b001111;
      5: op = 6'b001101;
      6: op = 6'b000101;
      7: op = 6'b100011;
      8: op = 6'b101011;
      default: op = 6'b000010;
    endcase
    return {op, h[25:0]};
  endfunction

  function automatic bit ref_illegal(input logic [31:0] w);
    logic [5:0] op;
    op = w[31:26];
    return !(op inside {6'b000000, 6'b001000, 6'b001011, 6'b000100,
                        6'b001111, 6'b001101, 6'b000101});
  endfunction

  function automatic logic [31:0] log_at(input int i);
    return (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF;
  endfunction

  // Expected stream from a base: consecutive words, 32-bit wrapping
  task automatic fill(input logic [31:0] base, input bit into_next);
    logic [31:0] a;
    a = base;
    if (into_next) next_q.delete(); else exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      if (into_next) next_q.push_back({a, memword(a)});
      else           exp_q.push_back({a, memword(a)});
      a = a + 32'd4;
    end
  endtask

  // Memory responder: one outstanding request, random grant and latency
  initial begin
    int          cnt;
    bit          pend;
    logic [31:0] paddr;
    cnt = 0; pend = 1'b0; paddr = '0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      if (!rst_i) begin
        pend = 1'b0;
        continue;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = memword(paddr);
          pend          = 1'b0;
        end
      end else if (imem_req_o && !gnt_block && ($urandom_range(99) < gnt_pct)) begin
        imem_gnt_i = 1'b1;
        paddr      = imem_addr_o;
        pend       = 1'b1;
        cnt        = $urandom_range(lat_max, lat_min);
        req_log.push_back(paddr);
      end
    end
  end

  // Monitor: pops expected entries on every handshake
  initial begin
    logic        pv, pr, prd;
    logic [31:0] pi, pp;
    logic [63:0] e;
    pv = 0; pr = 0; prd = 0; pi = '0; pp = '0;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        exp_q.delete();
        pv = 0; pr = 0; prd = 0;
        continue;
      end
      if (prd) begin
        check("valid_after_redirect", 32'(instr_valid_o), 32'd0);
      end else if (pv && !pr) begin
        check("hold_valid", 32'(instr_valid_o), 32'd1);
        check("hold_instr", instr_o, pi);
        check("hold_pc", instr_pc_o, pp);
      end
      if (instr_valid_o && instr_ready_i) begin
        pops++;
        if (exp_q.size() == 0) begin
          fail_now("unexpected_pop");
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", instr_pc_o, e[63:32]);
          check("pop_instr", instr_o, e[31:0]);
          check("pop_op", 32'(instr_op_o), 32'(e[31:26]));
          check("pop_illegal", 32'(instr_illegal_o), 32'(ref_illegal(e[31:0])));
        end
      end
      if (redirect_i) begin
        exp_q = next_q;
        next_q.delete();
      end
      pv = instr_valid_o; pr = instr_ready_i; prd = redirect_i;
      pi = instr_o; pp = instr_pc_o;
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic check_zero(input string p);
    check({p, "_req"}, 32'(imem_req_o), 32'd0);
    check({p, "_addr"}, imem_addr_o, 32'd0);
    check({p, "_valid"}, 32'(instr_valid_o), 32'd0);
    check({p, "_instr"}, instr_o, 32'd0);
    check({p, "_pc"}, instr_pc_o, 32'd0);
    check({p, "_op"}, 32'(instr_op_o), 32'd0);
    check({p, "_illegal"}, 32'(instr_illegal_o), 32'd0);
  endtask

  task automatic reset_hold(input logic [31:0] word, input bit fixed);
    rst_i        = 1'b0;
    redirect_i   = 1'b0;
    mem_fixed_en = fixed;
    mem_fixed    = word;
    repeat (3) cyc();
    req_log.delete();
  endtask

  task automatic reset_release();
    rst_i = 1'b1;
    fill(RST_PC, 1'b0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!instr_valid_o && n < 60) begin cyc(); n++; end
    if (!instr_valid_o) fail_now(name);
  endtask

  task automatic wait_log(input int size, input string name);
    int n;
    n = 0;
    while (req_log.size() < size && n < 80) begin cyc(); n++; end
    if (req_log.size() < size) fail_now(name);
  endtask

  initial begin
    int          n, j;
    logic [31:0] a, t;
    rst_i = 1'b0; instr_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;

    // Reset values, first request, in-order streaming
    reset_hold(32'h2008_0005, 1'b1);
    check_zero("rst");
    reset_release();
    cyc();
    check("first_req", 32'(imem_req_o), 32'd1);
    check("first_addr", imem_addr_o, RST_PC);
    wait_valid("t1_valid");
    check("t1_pc", instr_pc_o, 32'h0);
    check("t1_op", 32'(instr_op_o), 32'(6'b001000));
    check("t1_illegal", 32'(instr_illegal_o), 32'd0);
    wait_log(3, "t1_log");
    check("t1_addr0", log_at(0), 32'h0);
    check("t1_addr1", log_at(1), 32'h4);
    check("t1_addr2", log_at(2), 32'h8);

    // Stalled decode: buffer fills with two words, no third request
    instr_ready_i = 1'b0;
    reset_hold(32'h2008_0005, 1'b1);
    reset_release();
    repeat (12) cyc();
    check("t2_nreq", 32'(req_log.size()), 32'd2);
    check("t2_addr0", log_at(0), 32'h0);
    check("t2_addr1", log_at(1), 32'h4);
    check("t2_req_idle", 32'(imem_req_o), 32'd0);
    check("t2_valid", 32'(instr_valid_o), 32'd1);
    check("t2_head_pc", instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    wait_log(3, "t2_resume");
    check("t2_addr2", log_at(2), 32'h8);

    // Redirect while waiting for the response
    lat_min = 2; lat_max = 2;
    n = req_log.size();
    wait_log(n + 1, "t3_gnt");
    cyc();
    redirect_i = 1'b1; redirect_pc_i = 32'h40; fill(32'h40, 1'b1);
    cyc();
    redirect_i = 1'b0;
    wait_log(n + 2, "t3_next");
    check("t3_target_addr", log_at(n + 1), 32'h40);
    wait_valid("t3_valid");
    check("t3_target_pc", instr_pc_o, 32'h40);

    // Redirect while request is held off by the memory
    lat_min = 1; lat_max = 1;
    gnt_block = 1'b1;
    j = 0;
    while (!imem_req_o && j < 30) begin cyc(); j++; end
    check("t4_req", 32'(imem_req_o), 32'd1);
    n = req_log.size();
    a = imem_addr_o;
    redirect_i = 1'b1; redirect_pc_i = 32'h43; fill(32'h40, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc();
      redirect_i = 1'b0;
      check("t4_req_held", 32'(imem_req_o), 32'd1);
      check("t4_addr_held", imem_addr_o, a);
    end
    gnt_block = 1'b0;
    wait_log(n + 2, "t4_next");
    check("t4_old_addr", log_at(n), a);
    check("t4_target_addr", log_at(n + 1), 32'h40);

    // Illegal flag on unsupported and supported opcodes
    reset_hold(32'h8C00_0123, 1'b1);
    reset_release();
    wait_valid("t5a_valid");
    check("t5a_op", 32'(instr_op_o), 32'(6'b100011));
    check("t5a_illegal", 32'(instr_illegal_o), 32'd1);
    reset_hold(32'h1400_0123, 1'b1);
    reset_release();
    wait_valid("t5b_valid");
    check("t5b_op", 32'(instr_op_o), 32'(6'b000101));
    check("t5b_illegal", 32'(instr_illegal_o), 32'd0);

    // Asynchronous reset with one buffered word and a response in flight
    instr_ready_i = 1'b0;
    lat_min = 2; lat_max = 2;
    reset_hold(32'h2008_0005, 1'b1);
    reset_release();
    wait_log(2, "t6_second");
    cyc();
    check("t6_one_entry", 32'(instr_valid_o), 32'd1);
    check("t6_head_pc", instr_pc_o, 32'h0);
    rst_i = 1'b0;
    #1;
    check_zero("t6_async");
    reset_hold(32'h2008_0005, 1'b1);
    instr_ready_i = 1'b1;
    reset_release();
    cyc();
    check("t6_req", 32'(imem_req_o), 32'd1);
    check("t6_addr", imem_addr_o, RST_PC);

    // Random traffic with random redirects
    reset_hold(32'h0, 1'b0);
    gnt_pct = 70; lat_min = 1; lat_max = 3;
    reset_release();
    for (int i = 0; i < 1500; i++) begin
      cyc();
      instr_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(99) < 4) begin
        case ($urandom_range(3))
          0:       t = 32'hFFFF_FFF8;
          1:       t = 32'($urandom_range(255));
          default: t = $urandom;
        endcase
        redirect_i = 1'b1; redirect_pc_i = t;
        fill({t[31:2], 2'b00}, 1'b1);
      end else begin
        redirect_i = 1'b0;
      end
    end
    redirect_i = 1'b0; instr_ready_i = 1'b1;
    repeat (20) cyc();

    // PC wraps from 0xFFFF_FFFC to 0
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    n = req_log.size();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF9; fill(32'hFFFF_FFF8, 1'b1);
    cyc();
    redirect_i = 1'b0;
    wait_log(n + 5, "wrap_log");
    j = n;
    while (j < n + 2 && log_at(j) != 32'hFFFF_FFF8) j++;
    check("wrap_a0", log_at(j), 32'hFFFF_FFF8);
    check("wrap_a1", log_at(j + 1), 32'hFFFF_FFFC);
    check("wrap_a2", log_at(j + 2), 32'h0000_0000);
    repeat (20) cyc();
    check("pops_seen", 32'(pops > 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
    $fatal(1);
  end

endmodule
`default_nettype wire
